// File: rtl/count_up.sv
// Enable-gated binary up-counter that wraps from MAX_VAL back to zero.
// A timebase primitive: the parent compares count against thresholds and clears it through reset.
module count_up #(
  parameter int unsigned            WIDTH   = 8,
  parameter logic [WIDTH-1:0]       MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic at_max;

  assign at_max = (count == MAX_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end

  // tc is gated by enable, so it marks the cycle in which the wrap will actually happen.
  assign tc = enable & at_max;

endmodule

// File: tb/tb_count_up.sv
// Self-checking bench for count_up: a default-terminal instance and a MAX_VAL=9 instance.
// Expected values are queued as stimulus is driven and popped when the outputs are sampled.
module tb_count_up;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       t;
  } exp_t;

  logic       clk;
  logic       reset_a, enable_a, tc_a;
  logic       reset_b, enable_b, tc_b;
  logic [3:0] count_a, count_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  count_up #(.WIDTH(4)) u_dut_a (
    .clk    (clk),
    .reset  (reset_a),
    .enable (enable_a),
    .count  (count_a),
    .tc     (tc_a)
  );

  count_up #(.WIDTH(4), .MAX_VAL(4'd9)) u_dut_b (
    .clk    (clk),
    .reset  (reset_b),
    .enable (enable_b),
    .count  (count_b),
    .tc     (tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input logic [3:0] oc, input logic ot, input exp_t e);
    n_assert++;
    assert (oc === e.c) else begin
      n_fail++;
      $error("FAIL %s count: observed %0d expected %0d", e.tag, oc, e.c);
    end
    n_assert++;
    assert (ot === e.t) else begin
      n_fail++;
      $error("FAIL %s tc: observed %0b expected %0b", e.tag, ot, e.t);
    end
  endtask

  task automatic pop_a();
    exp_t e;
    if (qa.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_a: observed empty queue expected an entry");
    end else begin
      e = qa.pop_front();
      cmp(count_a, tc_a, e);
    end
  endtask

  task automatic pop_b();
    exp_t e;
    if (qb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_b: observed empty queue expected an entry");
    end else begin
      e = qb.pop_front();
      cmp(count_b, tc_b, e);
    end
  endtask

  // Drive enable, queue the post-edge expectation, then sample 1 ns after the edge.
  task automatic step_a(input string tag, input logic en, input logic [3:0] c, input logic t);
    enable_a = en;
    qa.push_back('{tag: tag, c: c, t: t});
    @(posedge clk);
    #1;
    pop_a();
  endtask

  task automatic step_b(input string tag, input logic en, input logic [3:0] c, input logic t);
    enable_b = en;
    qb.push_back('{tag: tag, c: c, t: t});
    @(posedge clk);
    #1;
    pop_b();
  endtask

  initial begin
    reset_a  = 1'b0;
    enable_a = 1'b0;
    reset_b  = 1'b0;
    enable_b = 1'b1;
    #2;
    qa.push_back('{tag: "reset_a", c: 4'd0, t: 1'b0});
    pop_a();
    qb.push_back('{tag: "reset_b", c: 4'd0, t: 1'b0});
    pop_b();
    enable_b = 1'b0;

    // Release reset away from the clock edge, then count 1..5.
    @(negedge clk);
    reset_a = 1'b1;
    for (int i = 1; i <= 5; i++) step_a("basic", 1'b1, 4'(i), 1'b0);

    // Hold at 5 for three edges, then one increment.
    for (int i = 0; i < 3; i++) step_a("hold", 1'b0, 4'd5, 1'b0);
    step_a("hold_inc", 1'b1, 4'd6, 1'b0);
    for (int i = 7; i <= 9; i++) step_a("to9", 1'b1, 4'(i), 1'b0);

    // Asynchronous clear between edges at count 9; observed before the next edge.
    @(negedge clk);
    reset_a = 1'b0;
    qa.push_back('{tag: "async_clr", c: 4'd0, t: 1'b0});
    #1;
    pop_a();
    for (int i = 0; i < 5; i++) step_a("in_reset", 1'b1, 4'd0, 1'b0);

    // Release and count up to 13, then wrap through 14, 15 (tc) and 0.
    @(negedge clk);
    reset_a = 1'b1;
    for (int i = 1; i <= 13; i++) step_a("to13", 1'b1, 4'(i), 1'b0);
    step_a("wrap14", 1'b1, 4'd14, 1'b0);
    step_a("wrap15", 1'b1, 4'd15, 1'b1);
    step_a("wrap0", 1'b1, 4'd0, 1'b0);
    step_a("hold_tc", 1'b0, 4'd0, 1'b0);

    // Reset asserted coincident with a clock edge at count 7: reset must win.
    for (int i = 1; i <= 7; i++) step_a("to7", 1'b1, 4'(i), 1'b0);
    @(posedge clk);
    reset_a = 1'b0;
    qa.push_back('{tag: "race_clr", c: 4'd0, t: 1'b0});
    #1;
    pop_a();
    @(negedge clk);
    reset_a = 1'b1;
    step_a("race_first", 1'b1, 4'd1, 1'b0);
    enable_a = 1'b0;

    // Custom terminal value 9: 8 -> 9 (tc) -> 0 -> 1, never 10.
    @(negedge clk);
    reset_b = 1'b1;
    for (int i = 1; i <= 8; i++) step_b("b_to8", 1'b1, 4'(i), 1'b0);
    step_b("b_term", 1'b1, 4'd9, 1'b1);
    step_b("b_wrap0", 1'b1, 4'd0, 1'b0);
    step_b("b_wrap1", 1'b1, 4'd1, 1'b0);
    step_b("b_hold", 1'b0, 4'd1, 1'b0);

    n_assert++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d/%0d left expected 0/0", qa.size(), qb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
